// File: rtl/pwm_servo_array_if.sv
// Bus between a controller and pwm_servo_array: width targets, load/fire
// strobes in one direction, PWM outputs and fire-sequencer status in the other.
interface pwm_servo_array_if #(
   parameter int NUM_CH = 3,
   parameter int CNT_W  = 20
);
   logic [NUM_CH*CNT_W-1:0] target;
   logic                    load;
   logic                    fire;
   logic [NUM_CH-1:0]       pwm_out;
   logic                    period_start;
   logic                    busy;
   logic                    fire_done;

   modport master (
      output target, load, fire,
      input  pwm_out, period_start, busy, fire_done
   );

   modport slave (
      input  target, load, fire,
      output pwm_out, period_start, busy, fire_done
   );
endinterface

// File: rtl/pwm_servo_array.sv
// pwm_servo_array: NUM_CH servo/motor PWM channels sharing one period counter.
// Width changes take effect only at period boundaries so every pulse is whole.
// A fire sequencer waits until all channels reach their targets, then holds
// channel FIRE_CH at MAX_PULSE for FIRE_PERIODS full periods.
// Optional feature macro: PWM_SLEW_LIMIT_EN -- when defined, each channel moves
// toward its target by at most SLEW_STEP per period; otherwise it jumps.
module pwm_servo_array #(
   parameter int NUM_CH        = 3,
   parameter int CNT_W         = 20,
   parameter int PERIOD_CYCLES = 1000000,
   parameter int MIN_PULSE     = 50000,
   parameter int MAX_PULSE     = 100000,
   parameter int SLEW_STEP     = 1000,
   parameter int FIRE_CH       = 2,
   parameter int FIRE_PERIODS  = 25
) (
   input logic              clock,
   input logic              reset,
   pwm_servo_array_if.slave bus
);

   // Arithmetic is done one bit wider than the counter so add/subtract and
   // compares can never wrap.
   localparam int XW = CNT_W + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYCLES - 1);
   localparam logic [XW-1:0]    MIN_X    = XW'(MIN_PULSE);
   localparam logic [XW-1:0]    MAX_X    = XW'(MAX_PULSE);
`ifdef PWM_SLEW_LIMIT_EN
   localparam logic [XW-1:0]    STEP_X   = XW'(SLEW_STEP);
`else
   // An all-ones step never limits the move, so cur jumps straight to tgt.
   localparam logic [XW-1:0]    STEP_X   = {XW{1'b1}};
`endif
   localparam int FP_W = (FIRE_PERIODS > 1) ? $clog2(FIRE_PERIODS) : 1;
   localparam logic [FP_W-1:0]  FIRE_LAST = FP_W'(FIRE_PERIODS - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_FIRE   = 2'd2,
      ST_DONE   = 2'd3
   } fire_state_t;

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] tgt_r      [NUM_CH];
   logic [CNT_W-1:0] cur_r      [NUM_CH];
   logic [CNT_W-1:0] tgt_next_s [NUM_CH];
   logic [CNT_W-1:0] cur_next_s [NUM_CH];
   logic [CNT_W-1:0] eff_s      [NUM_CH];
   logic [NUM_CH-1:0] pwm_r;
   logic             period_start_r;
   logic             busy_r;
   logic             fire_done_r;
   logic             boundary_s;
   logic             settled_s;
   fire_state_t      state_r;
   fire_state_t      state_next_s;
   logic [FP_W-1:0]  fire_cnt_r;
   logic [FP_W-1:0]  fire_cnt_next_s;

   // Limit a requested width to the legal servo range.
   function automatic logic [CNT_W-1:0] clamp_width(input logic [CNT_W-1:0] req);
      logic [XW-1:0] req_x;
      req_x = {1'b0, req};
      if (req_x < MIN_X) begin
         return MIN_X[CNT_W-1:0];
      end else if (req_x > MAX_X) begin
         return MAX_X[CNT_W-1:0];
      end else begin
         return req;
      end
   endfunction

   // Move cur toward tgt by at most STEP_X; the result always lies between
   // cur and tgt, so the widened top bit is always zero.
   function automatic logic [CNT_W-1:0] slew_toward(input logic [CNT_W-1:0] cur,
                                                    input logic [CNT_W-1:0] tgt);
      logic [XW-1:0] cur_x;
      logic [XW-1:0] tgt_x;
      logic [XW-1:0] diff_x;
      logic [XW-1:0] res_x;
      cur_x = {1'b0, cur};
      tgt_x = {1'b0, tgt};
      if (tgt_x >= cur_x) begin
         diff_x = tgt_x - cur_x;
         res_x  = cur_x + ((diff_x < STEP_X) ? diff_x : STEP_X);
      end else begin
         diff_x = cur_x - tgt_x;
         res_x  = cur_x - ((diff_x < STEP_X) ? diff_x : STEP_X);
      end
      return res_x[CNT_W-1:0];
   endfunction

   assign boundary_s = (cnt_r == LAST_CNT);

   // Next target/current widths and the "all channels settled" flag.
   always_comb begin
      settled_s = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         tgt_next_s[i] = tgt_r[i];
         cur_next_s[i] = cur_r[i];
         if (bus.load) begin
            tgt_next_s[i] = clamp_width(bus.target[i*CNT_W +: CNT_W]);
         end else begin
            tgt_next_s[i] = tgt_r[i];
         end
         if (boundary_s) begin
            cur_next_s[i] = slew_toward(cur_r[i], tgt_r[i]);
         end else begin
            cur_next_s[i] = cur_r[i];
         end
         if (cur_next_s[i] != tgt_next_s[i]) begin
            settled_s = 1'b0;
         end else begin
            settled_s = settled_s;
         end
      end
   end

   // Effective width per channel: fire override on FIRE_CH, else current width.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         eff_s[i] = cur_r[i];
         if ((state_r == ST_FIRE) && (i == FIRE_CH)) begin
            eff_s[i] = MAX_X[CNT_W-1:0];
         end else begin
            eff_s[i] = cur_r[i];
         end
      end
   end

   // Fire sequencer next-state logic.
   always_comb begin
      state_next_s    = state_r;
      fire_cnt_next_s = fire_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.fire) begin
               state_next_s = ST_SETTLE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (boundary_s && settled_s) begin
               state_next_s    = ST_FIRE;
               fire_cnt_next_s = {FP_W{1'b0}};
            end else begin
               state_next_s = ST_SETTLE;
            end
         end
         ST_FIRE: begin
            if (boundary_s) begin
               if (fire_cnt_r == FIRE_LAST) begin
                  state_next_s = ST_DONE;
               end else begin
                  fire_cnt_next_s = fire_cnt_r + FP_W'(1);
               end
            end else begin
               state_next_s = ST_FIRE;
            end
         end
         ST_DONE: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State registers, period counter and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_r          <= {CNT_W{1'b0}};
         for (int i = 0; i < NUM_CH; i++) begin
            tgt_r[i] <= MIN_X[CNT_W-1:0];
            cur_r[i] <= MIN_X[CNT_W-1:0];
         end
         pwm_r          <= {NUM_CH{1'b0}};
         state_r        <= ST_IDLE;
         fire_cnt_r     <= {FP_W{1'b0}};
         period_start_r <= 1'b0;
         busy_r         <= 1'b0;
         fire_done_r    <= 1'b0;
      end else begin
         cnt_r <= boundary_s ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
         for (int i = 0; i < NUM_CH; i++) begin
            tgt_r[i] <= tgt_next_s[i];
            cur_r[i] <= cur_next_s[i];
            pwm_r[i] <= ({1'b0, cnt_r} < {1'b0, eff_s[i]});
         end
         state_r        <= state_next_s;
         fire_cnt_r     <= fire_cnt_next_s;
         // Counter is 0 in the cycle right after the boundary.
         period_start_r <= boundary_s;
         busy_r         <= (state_next_s != ST_IDLE);
         fire_done_r    <= (state_next_s == ST_DONE);
      end
   end

   assign bus.pwm_out      = pwm_r;
   assign bus.period_start = period_start_r;
   assign bus.busy         = busy_r;
   assign bus.fire_done    = fire_done_r;

endmodule

// File: tb/tb_pwm_servo_array.sv
// Bench for pwm_servo_array with a short 100-cycle period: measures the high
// time of every channel in every period and compares it with expected widths
// queued when each stimulus record is applied.
module tb_pwm_servo_array;
   localparam int NUM_CH = 3;
   localparam int CNT_W  = 20;
   localparam int PER    = 100;

   logic clk;
   logic reset;

   pwm_servo_array_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus_if ();

   pwm_servo_array #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD_CYCLES(PER),
      .MIN_PULSE(10), .MAX_PULSE(20), .SLEW_STEP(2),
      .FIRE_CH(2), .FIRE_PERIODS(2)
   ) dut (
      .clock (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        do_load;
      logic [19:0] t0, t1, t2;
      logic        do_fire;
      int          e0, e1, e2;
      logic        exp_busy;
   } vec_t;

   typedef struct {
      int w0, w1, w2;
   } exp_t;

   vec_t vecs [11];
   exp_t sb_q [$];
   exp_t mon_exp;

   int   total = 0;
   int   bad   = 0;
   int   fd_cnt = 0;
   bit   mon_en = 1'b0;
   bit   started = 1'b0;
   int   per_len = 0;
   int   hi_cnt [NUM_CH];
   int   hi_man [NUM_CH];
   int   fd_saved;
   bit   ok;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_ps(output bit found);
      found = 1'b0;
      for (int n = 0; n < 250; n++) begin
         @(negedge clk);
         if (bus_if.period_start) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL period_start_timeout: got none expected pulse within 250 cycles");
      end
   endtask

   // Width monitor: one window per period, closed by each period_start.
   always @(negedge clk) begin
      if (!mon_en) begin
         started = 1'b0;
      end else begin
         if (bus_if.period_start) begin
            if (started) begin
               check("period_len", per_len, PER);
               if (sb_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL scoreboard_empty: got period with no expectation expected queued entry");
               end else begin
                  mon_exp = sb_q.pop_front();
                  check("width_ch0", hi_cnt[0], mon_exp.w0);
                  check("width_ch1", hi_cnt[1], mon_exp.w1);
                  check("width_ch2", hi_cnt[2], mon_exp.w2);
               end
            end
            started = 1'b1;
            per_len = 0;
            for (int i = 0; i < NUM_CH; i++) hi_cnt[i] = 0;
         end
         per_len++;
         for (int i = 0; i < NUM_CH; i++) begin
            if (bus_if.pwm_out[i]) hi_cnt[i]++;
         end
      end
   end

   // Counts fire_done pulses over the whole run.
   always @(negedge clk) begin
      if (bus_if.fire_done) fd_cnt++;
   end

   initial begin
      reset          = 1'b1;
      bus_if.target  = '0;
      bus_if.load    = 1'b0;
      bus_if.fire    = 1'b0;

`ifdef PWM_SLEW_LIMIT_EN
      vecs[0]  = '{1'b0, 20'd0,  20'd0,  20'd0,  1'b0, 10, 10, 10, 1'b0};
      vecs[1]  = '{1'b1, 20'd15, 20'd10, 20'd10, 1'b0, 10, 10, 10, 1'b0};
      vecs[2]  = '{1'b0, 20'd0,  20'd0,  20'd0,  1'b0, 12, 10, 10, 1'b0};
      vecs[3]  = '{1'b1, 20'd15, 20'd5,  20'd30, 1'b0, 14, 10, 10, 1'b0};
      vecs[4]  = '{1'b0, 20'd0,  20'd0,  20'd0,  1'b0, 15, 10, 12, 1'b0};
      vecs[5]  = '{1'b1, 20'd15, 20'd5,  20'd12, 1'b0, 15, 10, 14, 1'b0};
`else
      vecs[0]  = '{1'b0, 20'd0,  20'd0,  20'd0,  1'b0, 10, 10, 10, 1'b0};
      vecs[1]  = '{1'b1, 20'd15, 20'd10, 20'd10, 1'b0, 10, 10, 10, 1'b0};
      vecs[2]  = '{1'b0, 20'd0,  20'd0,  20'd0,  1'b0, 15, 10, 10, 1'b0};
      vecs[3]  = '{1'b1, 20'd15, 20'd5,  20'd30, 1'b0, 15, 10, 10, 1'b0};
      vecs[4]  = '{1'b0, 20'd0,  20'd0,  20'd0,  1'b0, 15, 10, 20, 1'b0};
      vecs[5]  = '{1'b1, 20'd15, 20'd5,  20'd12, 1'b0, 15, 10, 20, 1'b0};
`endif
      vecs[6]  = '{1'b0, 20'd0,  20'd0,  20'd0,  1'b0, 15, 10, 12, 1'b0};
      vecs[7]  = '{1'b0, 20'd0,  20'd0,  20'd0,  1'b1, 15, 10, 12, 1'b1};
      vecs[8]  = '{1'b0, 20'd0,  20'd0,  20'd0,  1'b1, 15, 10, 20, 1'b1};
      vecs[9]  = '{1'b0, 20'd0,  20'd0,  20'd0,  1'b0, 15, 10, 20, 1'b1};
      vecs[10] = '{1'b0, 20'd0,  20'd0,  20'd0,  1'b0, 15, 10, 12, 1'b0};

      // Reset state.
      repeat (4) @(negedge clk);
      check("reset_pwm_out", int'(bus_if.pwm_out), 0);
      check("reset_period_start", int'(bus_if.period_start), 0);
      check("reset_busy", int'(bus_if.busy), 0);
      check("reset_fire_done", int'(bus_if.fire_done), 0);
      reset = 1'b0;
      @(negedge clk);
      check("first_high", int'(bus_if.pwm_out), 7);

      mon_en = 1'b1;
      wait_ps(ok);

      // Table-driven periods: stimulus mid-period, expectation for this period.
      for (int k = 0; k < 11; k++) begin
         repeat (30) @(negedge clk);
         bus_if.target = {vecs[k].t2, vecs[k].t1, vecs[k].t0};
         bus_if.load   = vecs[k].do_load;
         bus_if.fire   = vecs[k].do_fire;
         sb_q.push_back('{vecs[k].e0, vecs[k].e1, vecs[k].e2});
         @(negedge clk);
         bus_if.load = 1'b0;
         bus_if.fire = 1'b0;
         check($sformatf("busy_vec%0d", k), int'(bus_if.busy), int'(vecs[k].exp_busy));
         wait_ps(ok);
      end
      @(negedge clk);
      mon_en = 1'b0;
      check("scoreboard_drained", sb_q.size(), 0);
      check("fire_done_count", fd_cnt, 1);

      // Reset in the middle of a fire sequence.
      fd_saved = fd_cnt;
      bus_if.fire = 1'b1;
      @(negedge clk);
      bus_if.fire = 1'b0;
      check("abort_busy_rise", int'(bus_if.busy), 1);
      wait_ps(ok);
      repeat (17) @(negedge clk);
      check("fire_override_pwm", int'(bus_if.pwm_out), 4);
      reset = 1'b1;
      @(negedge clk);
      check("abort_pwm_out", int'(bus_if.pwm_out), 0);
      check("abort_busy", int'(bus_if.busy), 0);
      check("abort_fire_done", int'(bus_if.fire_done), 0);
      check("abort_period_start", int'(bus_if.period_start), 0);
      reset = 1'b0;
      @(negedge clk);
      check("abort_first_high", int'(bus_if.pwm_out), 7);
      for (int i = 0; i < NUM_CH; i++) hi_man[i] = 0;
      for (int n = 0; n < PER; n++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (bus_if.pwm_out[i]) hi_man[i]++;
         end
         @(negedge clk);
      end
      check("abort_width_ch0", hi_man[0], 10);
      check("abort_width_ch1", hi_man[1], 10);
      check("abort_width_ch2", hi_man[2], 10);
      repeat (300) @(negedge clk);
      check("abort_no_fire_done", fd_cnt, fd_saved);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pwm_servo_array.md
PWM_SERVO_ARRAY -- requirements
Module: pwm_servo_array

Interface
REQ-001 Parameter NUM_CH, default 3, number of servo/motor PWM channels (arm, theta, motor).
REQ-002 Parameter CNT_W, default 20, width of period counter and pulse-width values.
REQ-003 Parameter PERIOD_CYCLES, default 1000000, PWM period in clock cycles (20 ms at 50 MHz).
REQ-004 Parameter MIN_PULSE, default 50000, minimum legal high time in cycles (1 ms).
REQ-005 Parameter MAX_PULSE, default 100000, maximum legal high time in cycles (2 ms).
REQ-006 Parameter SLEW_STEP, default 1000, maximum pulse-width change per period.
REQ-007 Parameter FIRE_CH, default 2, channel index driven by the fire sequence.
REQ-008 Parameter FIRE_PERIODS, default 25, number of full periods the fire pulse is held.
REQ-009 clock  input  1  system clock; one clock, all logic on rising edge.
REQ-010 reset  input  1  synchronous, active-high reset.
REQ-011 target  input  NUM_CH*CNT_W  requested pulse widths, channel i at bits [i*CNT_W +: CNT_W].
REQ-012 load  input  1  single-cycle strobe capturing target.
REQ-013 fire  input  1  single-cycle fire request.
REQ-014 pwm_out  output  NUM_CH  registered PWM outputs.
REQ-015 period_start  output  1  one-cycle pulse in the cycle the period counter equals 0.
REQ-016 busy  output  1  high while fire sequencer is not IDLE.
REQ-017 fire_done  output  1  one-cycle pulse at fire sequence completion.

Function
REQ-018 Period counter counts 0..PERIOD_CYCLES-1 and wraps to 0; "boundary" = cycle where counter equals PERIOD_CYCLES-1.
REQ-019 On load, each channel target register captures target clamped to [MIN_PULSE, MAX_PULSE], effective the next cycle.
REQ-020 Current width cur[i] updates only at a boundary, so a new width always starts at counter 0; no partial or glitched pulse.
REQ-021 pwm_out[i] is registered: pwm_out[i] <= (counter < eff[i]), one-cycle latency from counter; eff[i] = cur[i] except as REQ-026.
REQ-022 Comparisons and slew arithmetic use CNT_W+1 bits; no wrap-around on add/subtract.
REQ-023 Fire FSM states IDLE, SETTLE, FIRE, DONE; fire is ignored outside IDLE.
REQ-024 IDLE -> SETTLE on fire; busy rises the next cycle.
REQ-025 SETTLE -> FIRE at the first boundary where cur[i] == tgt[i] for all channels (evaluated with values after that boundary's update).
REQ-026 In FIRE, eff[FIRE_CH] = MAX_PULSE for exactly FIRE_PERIODS full periods starting at the next counter 0; cur[FIRE_CH] keeps tracking its target underneath.
REQ-027 FIRE -> DONE at the boundary ending the last fire period; DONE -> IDLE after one cycle with fire_done high.
REQ-028 load and fire in the same cycle: both accepted; SETTLE compares against the newly loaded targets.
REQ-029 load during SETTLE or FIRE is accepted; it may extend SETTLE but never shortens or cancels FIRE.

Reset
REQ-030 While reset is high: counter = 0, tgt[i] = cur[i] = MIN_PULSE, FSM = IDLE, pwm_out = 0, period_start = 0, busy = 0, fire_done = 0.
REQ-031 Reset mid-period or mid-fire aborts immediately; first pwm_out high occurs the cycle after reset deasserts; no fire_done is issued for an aborted sequence.

Configuration
REQ-032 Macro PWM_SLEW_LIMIT_EN defined: at each boundary cur[i] moves toward tgt[i] by min(|tgt[i]-cur[i]|, SLEW_STEP).
REQ-033 Macro PWM_SLEW_LIMIT_EN undefined: at each boundary cur[i] = tgt[i]; SLEW_STEP unused; SETTLE exits at first boundary.

Verification (bench params: NUM_CH=3, PERIOD_CYCLES=100, MIN_PULSE=10, MAX_PULSE=20, SLEW_STEP=2, FIRE_CH=2, FIRE_PERIODS=2)
REQ-034 Reset release, no load -> every channel high 10 cycles of each 100; period_start every 100 cycles.
REQ-035 load target ch0=15 mid-period -> current period stays 10 high; next periods 12,14,15 with slew macro, 15 immediately without.
REQ-036 load ch1=5 and ch2=30 -> widths clamp to 10 and 20.
REQ-037 fire with all channels settled -> busy next cycle; ch2 high 20 cycles for exactly 2 periods; fire_done one pulse; ch2 returns to its target.
REQ-038 second fire while busy -> ignored; exactly one fire_done.
REQ-039 reset asserted during FIRE -> all outputs 0 next cycle, busy 0, no fire_done, widths back to 10.
